// File: rtl/entropy_collector_pkg.sv
// Shared types and constants for the ring-oscillator entropy collector.
// ENTROPY_COLLECTOR_APT_EN enables the adaptive proportion test in entropy_health.
package entropy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    HOLD,
    FAIL
  } state_t;

  localparam int APT_WINDOW = 512;
  localparam int APT_CUTOFF = 410;

endpackage

// File: rtl/entropy_collector_health.sv
// Online health tests on captured oscillator bits: repetition count test always,
// adaptive proportion test only when ENTROPY_COLLECTOR_APT_EN is defined.
module entropy_health
  import entropy_pkg::*;
#(
  parameter int RCT_CUTOFF = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cap,
  input  logic sample,
  input  logic clear,
  output logic fail
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic [RW-1:0] run;
  logic          last;
  logic          rct_fail;

  // run == 0 marks "no bit seen yet"; it saturates at the cutoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= '0;
      last <= 1'b0;
    end else if (clear) begin
      run  <= '0;
      last <= 1'b0;
    end else if (cap) begin
      if (run != '0 && sample == last) begin
        if (run != RW'(RCT_CUTOFF)) run <= run + 1'b1;
      end else begin
        run <= RW'(1);
      end
      last <= sample;
    end
  end

  assign rct_fail = (run >= RW'(RCT_CUTOFF));

`ifdef ENTROPY_COLLECTOR_APT_EN
  localparam int AW = $clog2(APT_WINDOW);

  logic [AW-1:0] win_cnt;
  logic [AW:0]   ones;
  logic [AW:0]   ones_next;
  logic          apt_fail;

  assign ones_next = ones + {{AW{1'b0}}, sample};

  // The verdict includes the window's final bit; the window restarts either way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      ones     <= '0;
      apt_fail <= 1'b0;
    end else if (clear) begin
      win_cnt  <= '0;
      ones     <= '0;
      apt_fail <= 1'b0;
    end else if (cap) begin
      if (win_cnt == AW'(APT_WINDOW - 1)) begin
        win_cnt <= '0;
        ones    <= '0;
        if (ones_next > (AW+1)'(APT_CUTOFF) ||
            ones_next < (AW+1)'(APT_WINDOW - APT_CUTOFF))
          apt_fail <= 1'b1;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        ones    <= ones_next;
      end
    end
  end

  assign fail = rct_fail | apt_fail;
`else
  assign fail = rct_fail;
`endif

endmodule

// File: rtl/entropy_collector.sv
// Ring-oscillator entropy collector: warm-up, divided sampling, word assembly with
// valid/ready hand-off and sticky health failure. Optional APT via ENTROPY_COLLECTOR_APT_EN.
module entropy_collector
  import entropy_pkg::*;
#(
  parameter int WORD_W     = 64,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP_CYC = 256,
  parameter int RCT_CUTOFF = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              ro_en,
  output logic              ro_dff_en,
  input  logic              ro_bit,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              health_fail,
  input  logic              clear_fail
);

  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [7:0] DIV_LOAD = 8'(SAMPLE_DIV - 1);

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic [7:0]    div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          cap;
  logic          hclear;
  logic          fail;

  // The bit is taken on the edge after the strobe, while still collecting
  assign cap    = ro_dff_en && (state == COLLECT);
  assign hclear = (state == IDLE) || (state == FAIL);

  entropy_health #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_health (
    .clk   (clk),
    .rst   (rst),
    .cap   (cap),
    .sample(ro_bit),
    .clear (hclear),
    .fail  (fail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ro_en       <= 1'b0;
      ro_dff_en   <= 1'b0;
      word        <= '0;
      word_valid  <= 1'b0;
      health_fail <= 1'b0;
      warm_cnt    <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
    end else begin
      ro_dff_en <= 1'b0;
      case (state)
        IDLE: begin
          ro_en      <= 1'b0;
          word_valid <= 1'b0;
          if (enable) begin
            state    <= WARMUP;
            ro_en    <= 1'b1;
            warm_cnt <= WW'(WARMUP_CYC - 1);
          end
        end
        WARMUP: begin
          if (!enable) begin
            state <= IDLE;
            ro_en <= 1'b0;
          end else if (warm_cnt == '0) begin
            state   <= COLLECT;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt - 1'b1;
          end
        end
        COLLECT: begin
          if (fail) begin
            state       <= FAIL;
            health_fail <= 1'b1;
            ro_en       <= 1'b0;
            word        <= '0;
            word_valid  <= 1'b0;
          end else if (!enable) begin
            state      <= IDLE;
            ro_en      <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
          end else begin
            if (div_cnt == '0) begin
              ro_dff_en <= 1'b1;
              div_cnt   <= DIV_LOAD;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
            if (ro_dff_en) begin
              word <= {word[WORD_W-2:0], ro_bit};
              if (bit_cnt != BW'(WORD_W)) bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(WORD_W - 1)) begin
                state      <= HOLD;
                word_valid <= 1'b1;
                ro_dff_en  <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          // A pending failure wins over a same-cycle hand-off
          if (fail) begin
            state       <= FAIL;
            health_fail <= 1'b1;
            ro_en       <= 1'b0;
            word        <= '0;
            word_valid  <= 1'b0;
          end else if (!enable) begin
            state      <= IDLE;
            ro_en      <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
          end else if (word_ready) begin
            state      <= COLLECT;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= DIV_LOAD;
          end
        end
        FAIL: begin
          ro_en       <= 1'b0;
          word        <= '0;
          word_valid  <= 1'b0;
          health_fail <= 1'b1;
          if (clear_fail) begin
            state       <= IDLE;
            health_fail <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/entropy_collector.md
ENTROPY_COLLECTOR -- requirements
Module: entropy_collector

Interface
REQ-001 Parameter WORD_W, 64, output word width in bits (one SHA3 lane).
REQ-002 Parameter SAMPLE_DIV, 4, clocks between ring-oscillator samples; legal range 2..255.
REQ-003 Parameter WARMUP_CYC, 256, oscillator settling clocks before the first sample.
REQ-004 Parameter RCT_CUTOFF, 32, repetition-count failure threshold.
REQ-005 clk  in  1  single clock; all state is updated on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  level; 1 = run the collector.
REQ-008 ro_en  out  1  registered; drives the oscillator enable.
REQ-009 ro_dff_en  out  1  registered; one-clock sample strobe to the oscillator capture flops.
REQ-010 ro_bit  in  1  registered random bit from the oscillator.
REQ-011 word  out  WORD_W  assembled random word.
REQ-012 word_valid  out  1  word is available.
REQ-013 word_ready  in  1  consumer accepts word.
REQ-014 health_fail  out  1  sticky health-test failure flag.
REQ-015 clear_fail  in  1  one-clock pulse that clears a failure.

Function
REQ-016 The FSM SHALL have the states IDLE, WARMUP, COLLECT, HOLD and FAIL.
REQ-017 IDLE SHALL drive ro_en=0 and ro_dff_en=0; enable=1 SHALL move the FSM to WARMUP and load the warm-up counter.
REQ-018 WARMUP SHALL drive ro_en=1 for exactly WARMUP_CYC clocks and then enter COLLECT.
REQ-019 COLLECT SHALL pulse ro_dff_en high for one clock every SAMPLE_DIV clocks; the first pulse comes SAMPLE_DIV clocks after COLLECT is entered.
REQ-020 ro_bit SHALL be captured in the clock after each ro_dff_en pulse (one-clock capture latency) and shifted into the LSB of the word register, shifting left, so the first bit ends up in the MSB.
REQ-021 After WORD_W captures, the FSM SHALL enter HOLD with word_valid=1, and no ro_dff_en pulses SHALL occur in HOLD.
REQ-022 In HOLD, word SHALL stay stable while word_ready=0.
REQ-023 In HOLD, word_valid & word_ready SHALL complete the transfer and return the FSM to COLLECT with the bit count at 0 and the divider restarted.
REQ-024 In HOLD, ro_en SHALL remain 1 so that no re-warm-up is needed.
REQ-025 enable=0 in WARMUP, COLLECT or HOLD SHALL return the FSM to IDLE on the next clock: the partial or held word is discarded, word_valid drops and the health counters clear.
REQ-026 enable=0 SHALL be the only legal way for word_valid to fall without a transfer, apart from entering FAIL.
REQ-027 Repetition count test: the first captured bit SHALL set run=1; an identical next bit SHALL increment run; a different bit SHALL reset run to 1.
REQ-028 When run reaches RCT_CUTOFF, the FSM SHALL enter FAIL; run SHALL be preserved across HOLD.
REQ-029 FAIL SHALL drive health_fail=1, ro_en=0, ro_dff_en=0 and word_valid=0, and discard the word.
REQ-030 FAIL SHALL be left only by clear_fail=1, which goes to IDLE and clears health_fail; enable SHALL be ignored in FAIL.
REQ-031 If a failure and a handshake occur in the same clock, the failure SHALL take priority and the word SHALL not be transferred.
REQ-032 The run counter and the bit counter SHALL saturate and never wrap.

Reset
REQ-033 rst=1 SHALL asynchronously force: FSM=IDLE; ro_en=0; ro_dff_en=0; word=0; word_valid=0; health_fail=0; all counters=0.
REQ-034 Asserting reset mid-operation SHALL abandon any word and any failure state.

Configuration
REQ-035 With ENTROPY_COLLECTOR_APT_EN defined, an adaptive proportion test SHALL count ones over consecutive APT_WINDOW=512 captures.
REQ-036 Under ENTROPY_COLLECTOR_APT_EN, at each window end a ones count > APT_CUTOFF=410 or < 512-410=102 SHALL enter FAIL, and the window counters SHALL restart.
REQ-037 Without the macro, the APT logic SHALL be absent and only the repetition count test SHALL apply.

Structure
REQ-038 Package entropy_pkg SHALL hold the FSM state enum plus the APT_WINDOW and APT_CUTOFF constants.
REQ-039 Sub-module entropy_health SHALL implement the RCT and the conditional APT, taking capture strobe, bit and clear inputs and giving a fail output.

Verification
REQ-040 enable=1 with WARMUP_CYC=256, SAMPLE_DIV=4 -> ro_en=1 one clock later; first ro_dff_en exactly 256+4 clocks after WARMUP entry.
REQ-041 ro_bit alternating starting with 1, WORD_W=64, word_ready=1 -> word_valid after 64 captures with word=64'hAAAAAAAAAAAAAAAA; the next word follows with no gap beyond one divider period.
REQ-042 word_ready=0 for 100 clocks in HOLD -> word constant, zero ro_dff_en pulses; raising ready -> a single transfer, then COLLECT resumes.
REQ-043 ro_bit stuck at 0, RCT_CUTOFF=32 -> health_fail=1 on the clock after the 32nd capture, ro_en=0; clear_fail pulse -> IDLE, health_fail=0.
REQ-044 rst pulsed mid-COLLECT after 20 captures -> all outputs 0 immediately; enable held -> a full warm-up restarts.
REQ-045 With ENTROPY_COLLECTOR_APT_EN: 420 ones in a 512-capture window (no run >= 32) -> FAIL at the window end; 300 ones -> no failure.
